// File: rtl/check_node_row_scheduler.sv
// Row-serial check-node scheduler for a layered LDPC decoder: walks every parity-check row,
// then launches the variable-node update, repeating until the syndrome clears or MAX_ITER is hit.
module check_node_row_scheduler #(
    parameter int NUM_ROWS = 8,
    parameter int MAX_ITER = 10,
    parameter int ROW_W    = 3,
    parameter int ITER_W   = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start_decode,
    output logic              start_row_processing,
    input  logic              done_row_processing,
    output logic [ROW_W-1:0]  row_addr,
    output logic              start_vn_update,
    input  logic              done_vn_update,
    input  logic              syndrome_zero,
    output logic [ITER_W-1:0] iteration_count,
    output logic              busy,
    output logic              decode_done,
    output logic              converged
);

    typedef enum logic [2:0] {
        IDLE,
        ISSUE_ROW,
        WAIT_ROW,
        ISSUE_VN,
        WAIT_VN,
        FINISH
    } state_t;

    localparam logic [ROW_W-1:0]  LAST_ROW   = ROW_W'(NUM_ROWS - 1);
    localparam logic [ITER_W-1:0] ITER_LIMIT = ITER_W'(MAX_ITER);

    state_t            state;
    state_t            state_next;
    logic              row_last;
    logic [ITER_W-1:0] iter_inc;

    assign row_last = (row_addr == LAST_ROW);
    // Count saturates so a mis-set MAX_ITER can never wrap back to zero.
    assign iter_inc = (&iteration_count) ? iteration_count : iteration_count + ITER_W'(1);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:      if (start_decode) state_next = ISSUE_ROW;
            ISSUE_ROW: state_next = WAIT_ROW;
            WAIT_ROW: begin
                if (done_row_processing) begin
                    state_next = row_last ? ISSUE_VN : ISSUE_ROW;
                end
            end
            ISSUE_VN:  state_next = WAIT_VN;
            WAIT_VN: begin
                if (done_vn_update) begin
                    if (syndrome_zero || (iter_inc == ITER_LIMIT)) begin
                        state_next = FINISH;
                    end else begin
                        state_next = ISSUE_ROW;
                    end
                end
            end
            FINISH:    state_next = IDLE;
            default:   state_next = IDLE;
        endcase
    end

    // Row pointer, iteration counter and convergence flag only move on accepted handshakes.
    always_ff @(posedge clk) begin
        if (reset) begin
            row_addr        <= '0;
            iteration_count <= '0;
            converged       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_decode) begin
                        row_addr        <= '0;
                        iteration_count <= '0;
                        converged       <= 1'b0;
                    end
                end
                WAIT_ROW: begin
                    if (done_row_processing) begin
                        row_addr <= row_last ? '0 : row_addr + ROW_W'(1);
                    end
                end
                WAIT_VN: begin
                    if (done_vn_update) begin
                        iteration_count <= iter_inc;
                        if (syndrome_zero) begin
                            converged <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign start_row_processing = (state == ISSUE_ROW);
    assign start_vn_update      = (state == ISSUE_VN);
    assign decode_done          = (state == FINISH);
    assign busy                 = (state != IDLE);

endmodule
